// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and writeback requester indices.
package cpu_pkg;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int NREGS   = 2 ** ADDR_W;
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (valid == 2'b11)
                grant = ptr ? 2'b10 : 2'b01;
            else
                grant = valid;
        end
    end

    // Grant implies valid, so grant alone marks a completed handshake.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (grant[REQ_ALU])
            ptr <= 1'b1;
        else if (grant[REQ_LD])
            ptr <= 1'b0;
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// busy scoreboard for issue-stage stalls.
module regfile_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int ZERO_RO = 0,
    localparam int NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [NREGS-1:0]  busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
);
    logic [1:0]        grant;
    logic              hs;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREGS-1:0]  set_mask, clr_mask;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LD];
    assign hs         = |grant;
    assign wr_addr    = grant[REQ_LD] ? req1_addr : req0_addr;
    assign wr_data    = grant[REQ_LD] ? req1_data : req0_data;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid) set_mask[rsv_addr] = 1'b1;
        if (hs)        clr_mask[wr_addr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (hs) begin
            rf_addr <= wr_addr;
            rf_data <= wr_data;
            rf_we   <= !((ZERO_RO != 0) && (wr_addr == '0));
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Set after clear: a reservation landing with a write to the same reg is newer.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port (WE / inAddr / inData, written on negedge clk) between two writeback requesters: req0 is the ALU writeback and req1 is the load/immediate unit. Arbitration is round-robin with a valid/ready handshake. The block registers the winning write into the port one cycle after acceptance. It also keeps a per-register busy scoreboard so the issue stage can stall on pending destinations.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 3, register address width; NREGS = 2**ADDR_W (8)
ZERO_RO, 0, 1 = writes to address 0 are accepted (handshake completes, busy cleared) but rf_we is suppressed

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  ALU writeback request
req0_addr  in  ADDR_W  destination register
req0_data  in  DATA_W  write data
req0_ready  out  1  req0 accepted this cycle (combinational)
req1_valid  in  1  load-unit writeback request
req1_addr  in  ADDR_W  destination register
req1_data  in  DATA_W  write data
req1_ready  out  1  req1 accepted this cycle (combinational)
rsv_valid  in  1  issue stage reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
busy  out  NREGS  scoreboard; bit i = write to reg i pending
rf_we  out  1  to register-file WE
rf_addr  out  ADDR_W  to register-file inAddr
rf_data  out  DATA_W  to register-file inData

Behaviour:
- Reset (rst=1 at posedge):
  - rf_we=0, rf_addr=0, rf_data=0.
  - busy=0.
  - RR pointer=0, so req0 has priority.
  - req*_ready is forced to 0 during the reset cycle.
- Arbitration (combinational, every cycle):
  - Only req0 valid -> grant 0.
  - Only req1 valid -> grant 1.
  - Both valid -> grant the requester the pointer selects.
  - readyN = grant==N. At most one ready is high per cycle.
  - A handshake is validN & readyN.
- Pointer update: after a grant to N, the pointer moves to the other requester. No grant -> pointer holds.
- Write stage (posedge):
  - On a handshake, rf_addr and rf_data load the granted addr and data. rf_we=1, except rf_we=0 when ZERO_RO=1 and addr=0.
  - No handshake -> rf_we=0; rf_addr and rf_data hold their previous values.
  - Latency: handshake at posedge k -> rf_we high for cycle k..k+1 -> register file written at that cycle's negedge. Sustained throughput is 1 write/cycle.
- Requesters must hold valid, addr and data stable until ready. The block has no internal buffering beyond the single output register.
- Scoreboard (posedge):
  - rsv_valid sets busy[rsv_addr].
  - A write handshake clears busy[addr].
  - Same register reserved and accepted in the same cycle -> set wins (the new reservation is newer).
  - Reserving an already-busy register is legal; the bit stays 1 (no counting).
  - A handshake to a non-busy register is legal; the bit stays 0.
  - busy reflects the registered state and does not bypass the current cycle.
- Both requesters targeting the same address in one cycle: serialised in RR order over two cycles; the last accepted data is the final value.
- Reset mid-operation:
  - A pending rf_we is dropped; the register file is not written in the reset cycle.
  - busy is cleared.
  - Requesters must re-present their requests.

Decomposition:
- Shared package (cpu_pkg) holds the constants:
  - DATA_W, ADDR_W, NREGS.
  - Requester index constants REQ_ALU=0 and REQ_LD=1.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter with pointer state, inputs valid[1:0], output grant[1:0].
- The scoreboard and write register stay in the top module.

Test Plan:
1. Reset, then req0_valid=1, addr=3, data=16'hABCD -> req0_ready=1 same cycle; next cycle rf_we=1, rf_addr=3, rf_data=16'hABCD; the cycle after, rf_we=0.
2. req0 and req1 both valid for 4 cycles (req0 addr=1 data=0x0011, req1 addr=2 data=0x0022, held) -> grants 0,1,0,1; rf_addr sequence 1,2,1,2; never both ready in one cycle.
3. rsv_valid addr=5 -> busy=8'h20; then req1 write to addr=5 accepted -> busy=8'h00 next cycle.
4. Same cycle: rsv_valid addr=4 and req0 handshake to addr=4, with busy[4]=1 beforehand -> busy[4] stays 1; rf_we=1 with rf_addr=4.
5. ZERO_RO=1: req1 writes addr=0 data=0xFFFF -> req1_ready=1, rf_we stays 0, busy[0] cleared; with ZERO_RO=0 -> rf_we=1.
6. rst asserted the cycle after a handshake -> rf_we=0 in that cycle, busy=0, pointer=0; both requesters valid after reset -> req0 granted first.
